// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result handshake bundle for alu_mc.
// The master drives requests and out_ready; the slave drives results.
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_hi;
  logic [3:0]       flags;

  modport master (
    output in_valid, in_A, in_B, op, out_ready,
    input  in_ready, out_valid, out_hi, flags
  );

  modport slave (
    input  in_valid, in_A, in_B, op, out_ready,
    output in_ready, out_valid, out_hi, flags
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU, single-cycle ops plus a shift-add multiplier.
// Result, out_hi and flags {C,N,O,Z} are held until the consumer takes them.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_mc_if.slave          bus,
  input  logic             in_enable_out,
  output logic [WIDTH-1:0] out
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8;
  localparam logic [3:0] OP_SBB = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC;
  localparam logic [3:0] OP_MUL = 4'hD;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t             state;
  state_t             nxt;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   mcand;
  logic [3:0]         flg;
  logic               carry;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]     part;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic               add_ci;
  logic               sub_ci;
  logic               accept;
  logic               is_mul;
  logic               last;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_o;
  logic               alu_n;
  logic               alu_z;
  logic [3:0]         alu_f;
  logic [3:0]         mul_f;

  assign a      = bus.in_A;
  assign b      = bus.in_B;
  assign accept = bus.in_valid && bus.in_ready;
  assign is_mul = bus.op == OP_MUL;
  assign last   = cnt == CW'(WIDTH - 1);

  assign add_ci = (bus.op == OP_ADC) && carry;
  assign sub_ci = (bus.op == OP_SBB) && carry;
  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_ci};
  assign dif = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_ci};

  // one shift-add step: upper half grows by one bit, then shifts down
  assign part   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_nx = {part, acc[WIDTH-1:1]};
  assign mul_f  = {|acc_nx[2*WIDTH-1:WIDTH], acc_nx[M],
                   1'b0, acc_nx == '0};

  assign alu_f = {alu_c, alu_n, alu_o, alu_z};

  assign bus.out_hi = res_hi;
  assign bus.flags  = flg;
  assign out = in_enable_out ? res : {WIDTH{1'bz}};

  // single-cycle result and flags for the op at the handshake
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        alu_r = sum[M:0];
        alu_c = sum[WIDTH];
        alu_o = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB, OP_SBB: begin
        alu_r = dif[M:0];
        alu_c = dif[WIDTH];
        alu_o = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      OP_CMP: begin
        alu_r = a;
        alu_c = dif[WIDTH];
        alu_o = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      OP_OR:  alu_r = a | b;
      OP_AND: alu_r = a & b;
      OP_XOR: alu_r = a ^ b;
      OP_NOT: alu_r = ~a;
      OP_SHR: begin
        alu_r = {1'b0, a[M:1]};
        alu_c = a[0];
      end
      OP_SHL: begin
        alu_r = {a[M-1:0], 1'b0};
        alu_c = a[M];
      end
      OP_ROL: begin
        alu_r = {a[M-1:0], a[M]};
        alu_c = a[M];
      end
      OP_ROR: begin
        alu_r = {a[0], a[M:1]};
        alu_c = a[0];
      end
      default: ;
    endcase
    alu_n = (bus.op == OP_CMP) ? dif[M] : alu_r[M];
    alu_z = (bus.op == OP_CMP) ? (dif[M:0] == '0) : (alu_r == '0);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state: accept from IDLE/HOLD, finish mul, retire result
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = is_mul ? EXEC : HOLD;
      EXEC: if (last) nxt = HOLD;
      HOLD: begin
        if (accept)             nxt = is_mul ? EXEC : HOLD;
        else if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // handshake outputs from state
  always_comb begin
    bus.in_ready  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    bus.out_valid = state == HOLD;
  end

  // datapath: register results, carry and multiplier progress
  always_ff @(posedge clk) begin
    if (rst) begin
      res    <= '0;
      res_hi <= '0;
      flg    <= '0;
      carry  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        acc   <= {{WIDTH{1'b0}}, b};
        mcand <= a;
        cnt   <= '0;
      end else begin
        res    <= alu_r;
        res_hi <= '0;
        flg    <= alu_f;
        carry  <= alu_f[3];
      end
    end else if (state == EXEC) begin
      acc <= acc_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        res    <= acc_nx[WIDTH-1:0];
        res_hi <= acc_nx[2*WIDTH-1:WIDTH];
        flg    <= mul_f;
        carry  <= mul_f[3];
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed corner cases plus random ops checked
// against an integer-arithmetic reference model.
module tb_alu_mc;
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] f;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_enable_out = 1'b1;
  logic       tb_drv = 1'b0;
  wire  [7:0] out_w;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         mcy = 0;
  logic [7:0] got_out;
  logic [7:0] got_hi;
  logic [3:0] got_f;

  alu_mc_if #(.WIDTH(8)) bus ();

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .in_enable_out(in_enable_out),
    .out(out_w)
  );

  // weak-looking probe: drives 0 only while the DUT should float
  assign out_w = tb_drv ? 8'h00 : 8'bz;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [3:0] o, input int a,
                                 input int b, input int cin);
    res_t   r;
    int     sa, sb, s, ss, lo, hi, c, v, ci;
    longint p;
    logic   n, z;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    lo = 0; hi = 0; c = 0; v = 0; p = 0;
    case (o)
      4'h0, 4'h8: begin
        ci = (o == 4'h8) ? cin : 0;
        s  = a + b + ci;
        ss = sa + sb + ci;
        lo = s % 256;
        c  = (s >= 256) ? 1 : 0;
        v  = (ss > 127 || ss < -128) ? 1 : 0;
      end
      4'h1, 4'h9, 4'h5: begin
        ci = (o == 4'h9) ? cin : 0;
        s  = a - b - ci;
        ss = sa - sb - ci;
        lo = (s + 256) % 256;
        c  = (s < 0) ? 1 : 0;
        v  = (ss > 127 || ss < -128) ? 1 : 0;
      end
      4'h2: lo = a | b;
      4'h3: lo = a & b;
      4'hA: lo = a ^ b;
      4'h4: lo = 255 - a;
      4'h6: begin lo = a / 2; c = a % 2; end
      4'h7: begin lo = (a * 2) % 256; c = a / 128; end
      4'hB: begin lo = (a * 2) % 256 + a / 128; c = a / 128; end
      4'hC: begin lo = a / 2 + (a % 2) * 128; c = a % 2; end
      4'hD: begin
        p  = longint'(a) * longint'(b);
        lo = int'(p % 256);
        hi = int'(p / 256);
        c  = (hi != 0) ? 1 : 0;
      end
      default: ;
    endcase
    n = (lo >= 128);
    z = (o == 4'hD) ? (p == 0) : (lo == 0);
    if (o == 4'h5) lo = a;
    r.hi = 8'(hi);
    r.lo = 8'(lo);
    r.f  = {c[0], n, v[0], z};
    return r;
  endfunction

  // issue one op from IDLE at a negedge, check it, then retire it
  task automatic run_op(input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic en);
    res_t e;
    int   lat;
    e = model(o, int'(a), int'(b), mcy);
    bus.op = o;
    bus.in_A = a;
    bus.in_B = b;
    bus.in_valid = 1'b1;
    in_enable_out = en;
    tb_drv = !en;
    #1 chk("rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom);
    bus.in_A = 8'($urandom);
    bus.in_B = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk("busy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("lat", 32'(lat), (o == 4'hD) ? 32'd9 : 32'd1);
    chk("hi", 32'(bus.out_hi), 32'(e.hi));
    chk("flags", 32'(bus.flags), 32'(e.f));
    if (!en) begin
      chk("hiz", 32'(out_w), 32'd0);
      in_enable_out = 1'b1;
      tb_drv = 1'b0;
      #1;
    end
    chk("out", 32'(out_w), 32'(e.lo));
    got_out = out_w;
    got_hi = bus.out_hi;
    got_f = bus.flags;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("hold", 32'({bus.out_valid, bus.in_ready, out_w, bus.flags}),
          32'({1'b1, 1'b0, got_out, got_f}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    mcy = int'(e.f[3]);
  endtask

  initial begin
    logic [7:0] edges [5];
    logic [7:0] ra, rb;
    edges = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 4'h0;
    bus.in_A = 8'h00;
    bus.in_B = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_flg", 32'(bus.flags), 32'd0);
    chk("rst_out", 32'({bus.out_hi, out_w}), 32'd0);

    run_op(4'h0, 8'h7F, 8'h01, 1'b1);
    chk("add_7f", 32'({got_out, got_f}), 32'({8'h80, 4'b0110}));
    run_op(4'h1, 8'h00, 8'h01, 1'b1);
    chk("sub_0", 32'({got_out, got_f}), 32'({8'hFF, 4'b1100}));
    run_op(4'h9, 8'h05, 8'h02, 1'b1);
    chk("sbb_5", 32'({got_out, got_f}), 32'({8'h02, 4'b0000}));
    run_op(4'hD, 8'h0F, 8'h11, 1'b1);
    chk("mul_ff", 32'({got_hi, got_out, got_f}),
        32'({8'h00, 8'hFF, 4'b0100}));
    run_op(4'hD, 8'h10, 8'h10, 1'b1);
    chk("mul_100", 32'({got_hi, got_out, got_f}),
        32'({8'h01, 8'h00, 4'b1000}));

    // back-to-back: request waits while result is held
    bus.op = 4'h0;
    bus.in_A = 8'h03;
    bus.in_B = 8'h04;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.op = 4'hA;
    bus.in_A = 8'hF0;
    bus.in_B = 8'h0F;
    repeat (3) begin
      #1 chk("b2b_wait",
             32'({bus.out_valid, bus.in_ready, out_w, bus.flags}),
             32'({1'b1, 1'b0, 8'h07, 4'b0000}));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("b2b_new", 32'({bus.out_valid, out_w, bus.flags}),
        32'({1'b1, 8'hFF, 4'b0100}));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    mcy = 0;

    // reset in the middle of a multiply
    bus.op = 4'hD;
    bus.in_A = 8'h0F;
    bus.in_B = 8'h11;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_vld", 32'(bus.out_valid), 32'd0);
    chk("abort_rdy", 32'(bus.in_ready), 32'd1);
    chk("abort_flg", 32'(bus.flags), 32'd0);
    mcy = 0;
    @(negedge clk);
    run_op(4'h8, 8'h01, 8'h01, 1'b1);
    chk("adc_rst", 32'(got_out), 32'h02);

    run_op(4'h5, 8'h05, 8'h05, 1'b0);
    chk("cmp_eq", 32'({got_out, got_f}), 32'({8'h05, 4'b0001}));

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)]
                                       : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)]
                                       : 8'($urandom);
      run_op(4'($urandom_range(0, 15)), ra, rb,
             $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be legal for any value 4..32.
REQ-002 clk  input  1  the single clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_A, in_B  input  WIDTH each  operands, unsigned bit vectors.
REQ-007 op  input  4  operation code (REQ-014).
REQ-008 out_valid  output  1  result and flags held and valid.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out  output  WIDTH  result, or high-impedance (REQ-024).
REQ-011 out_hi  output  WIDTH  upper product half for mul, else 0.
REQ-012 flags  output  4  {C,N,O,Z}, registered with the result.
REQ-013 in_enable_out  input  1  tri-state enable for out.

Function
REQ-014 op encodings SHALL be: 0 add, 1 sub, 2 or, 3 and, 4 not(A), 5 cmp, 6 shr(A), 7 shl(A), 8 adc, 9 sbb, A xor, B rol(A), C ror(A), D mul, E/F reserved.
REQ-015 States SHALL be IDLE, EXEC, HOLD; IDLE and HOLD are the only states entered from reset/completion.
REQ-016 Request accepted when in_valid && in_ready; in_A, in_B, op sampled only at acceptance, ignored afterwards.
REQ-017 in_ready SHALL be 1 in IDLE, or in HOLD when out_ready=1 (back-to-back); 0 in EXEC.
REQ-018 Non-mul op: result/flags registered on the accepting edge; out_valid=1 the next cycle (latency 1), state HOLD.
REQ-019 mul: unsigned shift-add, one partial product per cycle, state EXEC for WIDTH cycles; out_valid rises exactly WIDTH+1 cycles after acceptance; out=product[WIDTH-1:0], out_hi=product[2*WIDTH-1:WIDTH].
REQ-020 HOLD: out, out_hi, flags SHALL stay stable until out_valid && out_ready; then IDLE, or a new op if accepted the same cycle.
REQ-021 add/adc: WIDTH+1-bit sum, adc adds stored carry; sub/sbb/cmp: WIDTH+1-bit A-B (sbb also subtracts stored carry), C = bit WIDTH (borrow).
REQ-022 cmp: out=A; C,N,O,Z from A-B (Z=1 iff A==B).
REQ-023 C: shr/ror = A[0]; shl/rol = A[WIDTH-1]; mul = (out_hi!=0); logic ops 0. O: signed overflow for add/adc/sub/sbb/cmp, else 0. N: MSB of out (cmp: of difference). Z: out==0 (mul: full product==0).
REQ-024 out SHALL be high-impedance whenever in_enable_out=0, regardless of state; other outputs unaffected.
REQ-025 Stored carry SHALL update to C whenever a result is registered; adc/sbb use the value at acceptance.
REQ-026 Reserved op: out=0, out_hi=0, flags=4'b0001, latency 1, stored carry cleared.
REQ-027 Shifts by one bit; shr/shl fill 0; rol/ror rotate within WIDTH.

Reset
REQ-028 rst=1 SHALL force IDLE, out_valid=0, in_ready=1 next cycle, internal out/out_hi=0, flags=0, stored carry=0.
REQ-029 rst SHALL abort any mul in EXEC and discard any held result; rst wins over simultaneous acceptance.

Verification (WIDTH=8)
REQ-030 add 0x7F+0x01 -> next cycle out_valid=1, out=0x80, flags=4'b0110.
REQ-031 sub 0x00-0x01 -> out=0xFF, flags=4'b1100; then sbb 0x05-0x02 -> out=0x02, flags=4'b0000.
REQ-032 mul 0x0F*0x11 -> in_ready=0 during EXEC, out_valid exactly 9 cycles after acceptance, out=0xFF, out_hi=0x00, flags=4'b0100; mul 0x10*0x10 -> out=0x00, out_hi=0x01, flags=4'b1000.
REQ-033 out_ready=0 for 3 cycles with in_valid=1 -> no acceptance, out/flags stable; out_ready=1 -> new op accepted that cycle, its result next cycle.
REQ-034 rst on 4th EXEC cycle -> next cycle out_valid=0, in_ready=1, flags=0; following adc 0x01+0x01 -> out=0x02.
REQ-035 in_enable_out=0 with cmp 0x05,0x05 -> out=Z, flags=4'b0001; raise enable -> out=0x05.
